lu_sweep_ctrl: RTL and testbench
================================

// Module: lu_sweep_ctrl
// PURPOSE
//  Controller that drives the select/operand side of the 2-input logic unit (LU: ctrl1/ctrl2 select
//  AND/NAND/OR/NOR on a,b). On start it drives all 16 {ctrl1,ctrl2,a,b} vectors, samples LU output y,
//  builds a 16-bit truth table and counts mismatches against the golden table. It is the on-chip
//  self-test master for the LU and sits between the test/CSR logic and the LU instance.
// PARAMETERS
//  SETTLE_CYCLES  1        extra cycles each vector is held before y is sampled (>=0)
//  GOLDEN         16'h17E8 expected table; bit i = y for i = {ctrl1,ctrl2,a,b}
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   request a sweep; sampled only in IDLE
//  lu_y       in   1   LU output
//  lu_ctrl1   out  1   LU select: 0 = AND/OR, 1 = NAND/NOR (registered)
//  lu_ctrl2   out  1   LU select: 0 = AND/NAND group, 1 = OR/NOR group (registered)
//  lu_a       out  1   LU operand a (registered)
//  lu_b       out  1   LU operand b (registered)
//  busy       out  1   high while sweeping
//  done       out  1   one-cycle pulse; table/err_count valid
//  table      out  16  captured truth table, bit i = sampled y for vector i
//  err_count  out  5   number of bits where table != GOLDEN (0..16)
//  pass       out  1   high when err_count == 0 (valid from done until next start)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (lu_*, busy, done, table, err_count, pass); idx=0, wait=0.
//  Vector index idx[3:0] drives {lu_ctrl1,lu_ctrl2,lu_a,lu_b} = idx (ctrl1 is MSB).
//  Golden map: {c1,c2}=00 AND, 01 OR, 10 NAND, 11 NOR -> GOLDEN = 16'h17E8.
//  FSM states: IDLE, DRIVE, DONE.
//   IDLE : start=1 at edge -> DRIVE; idx<=0, wait<=0, table<=0, err_count<=0, pass<=0, busy<=1.
//          start=0 -> stay; lu_* hold last driven vector.
//   DRIVE: each vector held exactly SETTLE_CYCLES+1 cycles. wait counts 0..SETTLE_CYCLES.
//          At edge with wait==SETTLE_CYCLES: table[idx]<=lu_y; if lu_y!=GOLDEN[idx] err_count+=1;
//          then if idx==15 -> DONE (busy<=0, done<=1, pass<=(final err_count==0)),
//          else idx<=idx+1, wait<=0 (new vector driven same edge).
//   DONE : one cycle only; done<=0 next edge; -> IDLE unconditionally. start here is ignored.
//  Latency: done is high in the cycle starting 16*(SETTLE_CYCLES+1) edges after the start edge
//   (32 for default). busy high for exactly 16*(SETTLE_CYCLES+1) cycles.
//  start while busy or in DONE: ignored, no restart, no queueing.
//  err_count saturates by construction at 16 (5 bits, no wrap). idx wraps only via DONE.
//  table/err_count/pass hold after DONE until the next accepted start.
//  reset mid-sweep: immediate return to IDLE, all outputs 0, partial table discarded; no done.
//  lu_y is assumed combinational from lu_* outputs; settle covered by SETTLE_CYCLES.
// TESTING
//  1 Behavioural LU model, SETTLE=1, pulse start -> done at edge 32, table=16'h17E8, err=0, pass=1.
//  2 lu_y stuck-at-0 -> table=16'h0000, err_count=8, pass=0; stuck-at-1 -> table=16'hFFFF, err=8.
//  3 LU output inverted -> table=16'hE817, err_count=16, pass=0.
//  4 start held high throughout sweep and during DONE -> exactly one done per accepted start;
//    second sweep starts in IDLE cycle after DONE; busy high 32 cycles each.
//  5 reset asserted at vector idx=7 (async, mid-cycle) -> outputs 0 immediately, no done pulse;
//    fresh start afterwards gives table=16'h17E8.
//  6 SETTLE_CYCLES=3 -> each {ctrl1,ctrl2,a,b} stable 4 cycles, done at edge 64, table=16'h17E8.

Source files
------------

// File: rtl/lu_sweep_ctrl.sv
// Self-test master for the 2-input logic unit: sweeps all 16 {ctrl1,ctrl2,a,b}
// vectors, captures the LU output into a truth table and counts mismatches
// against the golden table.
module lu_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] GOLDEN        = 16'h17E8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        lu_y,
    output logic        lu_ctrl1,
    output logic        lu_ctrl2,
    output logic        lu_a,
    output logic        lu_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  err_count,
    output logic        pass
);

    localparam int unsigned WAIT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                miss_c;
    logic [4:0]          err_nxt_c;

    // Mismatch of the current sample and the error count including it.
    assign miss_c    = lu_y ^ GOLDEN[idx];
    assign err_nxt_c = err_count + 5'(miss_c);

    // Sweep FSM: drives one vector per SETTLE_CYCLES+1 cycles and samples at the end of each.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 4'd0;
            wait_cnt    <= '0;
            lu_ctrl1    <= 1'b0;
            lu_ctrl2    <= 1'b0;
            lu_a        <= 1'b0;
            lu_b        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 16'h0000;
            err_count   <= 5'd0;
            pass        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= DRIVE;
                        idx         <= 4'd0;
                        wait_cnt    <= '0;
                        {lu_ctrl1, lu_ctrl2, lu_a, lu_b} <= 4'd0;
                        truth_table <= 16'h0000;
                        err_count   <= 5'd0;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (wait_cnt == WAIT_W'(SETTLE_CYCLES)) begin
                        truth_table[idx] <= lu_y;
                        err_count        <= err_nxt_c;
                        if (idx == 4'd15) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt_c == 5'd0);
                        end else begin
                            idx      <= idx + 4'd1;
                            wait_cnt <= '0;
                            {lu_ctrl1, lu_ctrl2, lu_a, lu_b} <= idx + 4'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lu_sweep_ctrl.sv
// Randomized self-checking bench for lu_sweep_ctrl with a behavioural LU model.
module tb_lu_sweep_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // LU fault model: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted, 4 random flip mask
    int          mode = 0;
    logic [15:0] mask = 16'h0000;

    logic start1 = 1'b0, start3 = 1'b0;
    logic y1, c1_1, c2_1, a_1, b_1, busy1, done1, pass1;
    logic y3, c1_3, c2_3, a_3, b_3, busy3, done3, pass3;
    logic [15:0] tt1, tt3;
    logic [4:0]  err1, err3;

    lu_sweep_ctrl #(.SETTLE_CYCLES(1), .GOLDEN(16'h17E8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .lu_y(y1),
        .lu_ctrl1(c1_1), .lu_ctrl2(c2_1), .lu_a(a_1), .lu_b(b_1),
        .busy(busy1), .done(done1), .truth_table(tt1), .err_count(err1), .pass(pass1));

    lu_sweep_ctrl #(.SETTLE_CYCLES(3), .GOLDEN(16'h17E8)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .lu_y(y3),
        .lu_ctrl1(c1_3), .lu_ctrl2(c2_3), .lu_a(a_3), .lu_b(b_3),
        .busy(busy3), .done(done3), .truth_table(tt3), .err_count(err3), .pass(pass3));

    // Behavioural LU: {c1,c2} = 00 AND, 01 OR, 10 NAND, 11 NOR, then the fault model.
    function automatic logic lu_fn(input int m, input logic [15:0] msk, input logic [3:0] v);
        logic base, good;
        base = v[2] ? (v[1] | v[0]) : (v[1] & v[0]);
        good = v[3] ? ~base : base;
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~good;
            4:       return good ^ msk[v];
            default: return good;
        endcase
    endfunction

    assign y1 = lu_fn(mode, mask, {c1_1, c2_1, a_1, b_1});
    assign y3 = lu_fn(mode, mask, {c1_3, c2_3, a_3, b_3});

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected table, error count and pass from the LU model and the fault-free LU.
    logic [15:0] exp_tt;
    int          exp_err;

    task automatic build_expect();
        exp_tt  = 16'h0000;
        exp_err = 0;
        for (int i = 0; i < 16; i++) begin
            exp_tt[i] = lu_fn(mode, mask, 4'(i));
            if (exp_tt[i] != lu_fn(0, 16'h0000, 4'(i))) exp_err++;
        end
    endtask

    // Monitored DUT selection (0 -> SETTLE 1, 1 -> SETTLE 3).
    int sel = 0;
    logic        busy_m, done_m, pass_m;
    logic [3:0]  vec_m;
    logic [15:0] tt_m;
    logic [4:0]  err_m;
    assign busy_m = sel ? busy3 : busy1;
    assign done_m = sel ? done3 : done1;
    assign pass_m = sel ? pass3 : pass1;
    assign vec_m  = sel ? {c1_3, c2_3, a_3, b_3} : {c1_1, c2_1, a_1, b_1};
    assign tt_m   = sel ? tt3 : tt1;
    assign err_m  = sel ? err3 : err1;

    // Samples ncyc cycles at negedge; start kept high while k < hold; tracks vector timing.
    int dones, busy_cyc, first_done, vec_errs;
    task automatic monitor(input int ncyc, input int hold, input int settle);
        int run;
        dones = 0; busy_cyc = 0; first_done = -1; vec_errs = 0; run = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (busy_m) begin
                if (int'(vec_m) != run / (settle + 1)) vec_errs++;
                run++;
                busy_cyc++;
            end else begin
                run = 0;
            end
            if (done_m) begin
                dones++;
                if (first_done < 0) first_done = k;
            end
            if (sel != 0) start3 = (k < hold);
            else          start1 = (k < hold);
        end
    endtask

    task automatic sweep(input string tag, input int s, input int hold, input int ncyc,
                         input int exp_dones);
        int settle;
        sel    = s;
        settle = (s != 0) ? 3 : 1;
        build_expect();
        @(negedge clk);
        if (s != 0) start3 = 1'b1;
        else        start1 = 1'b1;
        @(posedge clk);
        monitor(ncyc, hold, settle);
        check({tag, ".table"}, 32'(tt_m), 32'(exp_tt));
        check({tag, ".err"},   32'(err_m), 32'(exp_err));
        check({tag, ".pass"},  32'(pass_m), 32'(exp_err == 0));
        check({tag, ".dones"}, 32'(dones), 32'(exp_dones));
        check({tag, ".done_at"}, 32'(first_done), 32'(16 * (settle + 1)));
        check({tag, ".busy"},  32'(busy_cyc), 32'(exp_dones * 16 * (settle + 1)));
        check({tag, ".vecseq"}, 32'(vec_errs), 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        check("rst.busy", 32'(busy1), 32'd0);
        check("rst.done", 32'(done1), 32'd0);
        check("rst.table", 32'(tt1), 32'd0);
        check("rst.err", 32'(err1), 32'd0);
        check("rst.pass", 32'(pass1), 32'd0);
        check("rst.vec", 32'({c1_1, c2_1, a_1, b_1}), 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle.busy", 32'(busy1), 32'd0);

        mode = 0; sweep("good", 0, 0, 40, 1);
        mode = 1; sweep("stuck0", 0, 0, 40, 1);
        mode = 2; sweep("stuck1", 0, 0, 40, 1);
        mode = 3; sweep("invert", 0, 0, 40, 1);
        for (int r = 0; r < 6; r++) begin
            mode = 4;
            mask = 16'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            sweep("rand", 0, 0, 40, 1);
        end

        // start held through both sweeps and DONE: two accepted starts back to back
        mode = 0; mask = 16'h0000;
        sweep("hold", 0, 66, 100, 2);

        // async reset at vector 7, mid-cycle
        sel = 0;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        @(negedge clk) start1 = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        check("mid.vec_pre", 32'({c1_1, c2_1, a_1, b_1}), 32'd7);
        reset = 1'b1;
        #1;
        check("mid.busy", 32'(busy1), 32'd0);
        check("mid.table", 32'(tt1), 32'd0);
        check("mid.err", 32'(err1), 32'd0);
        check("mid.vec", 32'({c1_1, c2_1, a_1, b_1}), 32'd0);
        check("mid.done", 32'(done1), 32'd0);
        @(negedge clk) reset = 1'b0;
        monitor(40, 0, 1);
        check("mid.nodone", 32'(dones), 32'd0);
        sweep("after_rst", 0, 0, 40, 1);

        // longer settle
        mode = 4; mask = 16'($urandom);
        sweep("settle3_rand", 1, 0, 70, 1);
        mode = 0; mask = 16'h0000;
        sweep("settle3", 1, 0, 70, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
